release_sink_unit: RTL and testbench
====================================

Name: release_sink_unit

Overview:
- Manager-side endpoint of the TileLink C channel; the counterpart of the client's write-back and probe units that send Release, ReleaseData, ProbeAck and ProbeAckData.
- Accepts C messages, streams any data beats to the backing data-array write port, and answers each Release/ReleaseData with a single D-channel ReleaseAck.
- Reports completed ProbeAck/ProbeAckData upward to the probe tracker.

Parameters:
- BEAT_BYTES, 16, bytes per data beat; fixes the C/D data width at 128 bits.
- MAX_SIZE, 6, largest legal log2 transfer size (64 B = 4 beats).
- SINK_ID, 0, constant value driven on d_sink.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- c_valid  in  1  C beat valid.
- c_ready  out  1  C beat accepted.
- c_opcode  in  3  4 = ProbeAck, 5 = ProbeAckData, 6 = Release, 7 = ReleaseData.
- c_param  in  3  shrink/report param.
- c_size  in  4  log2 bytes.
- c_source  in  3  client source id.
- c_address  in  32  line address.
- c_data  in  128  beat data.
- d_valid  out  1  ReleaseAck valid.
- d_ready  in  1  D accepted.
- d_opcode  out  3  always 6 (ReleaseAck) while d_valid.
- d_param  out  2  always 0.
- d_size  out  4  echoed c_size.
- d_source  out  3  echoed c_source.
- d_sink  out  4  SINK_ID.
- d_data  out  128  always 0.
- wb_valid  out  1  data-array write valid.
- wb_ready  in  1  data-array write accepted.
- wb_addr  out  32  beat byte address.
- wb_data  out  128  beat data.
- wb_last  out  1  final beat of the message.
- probe_done  out  1  one-cycle pulse when a ProbeAck* completes.
- probe_source  out  3  source of the completed probe ack.
- probe_param  out  3  param of the completed probe ack.
- err  out  1  one-cycle pulse on an illegal opcode or size.

Behaviour:
- Reset (asynchronous, reset_n = 0): state IDLE, beat counter 0, captured fields 0. All outputs 0, including c_ready, d_valid, wb_valid, probe_done and err. Reset mid-message abandons the message; no ack is issued.
- Data opcodes are 5 and 7.
- Beat count N = 1 if c_size <= 4, else 1 << (c_size - 4).
- c_size > MAX_SIZE: pulse err; treat the message as MAX_SIZE (N = 4).
- States: IDLE, DATA, ACK.
- IDLE:
  - c_ready = 1 for non-data opcodes; c_ready = wb_ready for data opcodes.
  - On a C fire, capture opcode, param, size, source and address (address aligned down to BEAT_BYTES).
  - A data opcode with N > 1 goes to DATA with counter = 1.
  - A single-beat message completes immediately (see Completion).
- DATA:
  - c_ready = wb_ready; each C fire writes one beat and increments the counter.
  - When the counter reaches N - 1, the fire is the last beat; counter returns to 0 and the message completes.
  - Header fields on later beats are ignored.
- Write path is combinational pass-through for beats of data opcodes:
  - wb_valid = c_valid && (state is IDLE or DATA).
  - wb_data = c_data.
  - wb_addr = captured or current base + counter * BEAT_BYTES; wraps modulo the line, no carry into upper bits.
  - wb_last = 1 on beat N - 1.
  - Beats of non-data opcodes never assert wb_valid.
- Completion:
  - Release/ReleaseData: go to ACK next cycle.
  - ProbeAck/ProbeAckData: pulse probe_done with the captured source/param in the cycle after the last fire, then go to IDLE.
- Opcodes 0–3: accept as a single beat, pulse err, drop the message, stay in IDLE; no wb write, no ack.
- ACK:
  - c_ready = 0.
  - d_valid = 1 with d_opcode 6, d_param 0, d_sink SINK_ID, d_data 0, and the captured size and source; all D fields stable until d_ready.
  - On a D fire, go to IDLE. c_ready is not asserted in the fire cycle, giving a one-cycle turnaround minimum.
- Latency:
  - Single-beat Release: C fire in cycle t, d_valid rises at t+1, next C accept at t+2 at the earliest if d_ready = 1.
  - Only one message is in flight at a time.

Test Plan:
- Release (opcode 6), size 6, source 3, d_ready = 1 -> no wb writes; d_valid at t+1 with opcode 6, size 6, source 3, sink 0; c_ready low at t+1.
- ReleaseData, size 6, address 0x1000, four beats D0–D3, wb_ready = 1 -> wb_addr 0x1000, 0x1010, 0x1020, 0x1030; wb_last only on D3; one ReleaseAck afterwards.
- Same ReleaseData with wb_ready toggled 1,0,0,1,1,0,1 -> c_ready mirrors wb_ready; exactly 4 wb fires, beat order preserved, one ack.
- ProbeAckData, size 6, source 2, param 1 -> 4 wb writes; probe_done pulses one cycle with source 2, param 1; d_valid never asserts.
- ReleaseAck held with d_ready = 0 for 5 cycles -> D fields stable, c_ready = 0 throughout; return to IDLE after the fire.
- Opcode 2, then c_size 7 ReleaseData -> err pulse and drop for the first; err pulse for the second, processed as 4 beats and acked; reset_n pulsed mid-DATA -> all outputs 0 and no ack.

Source files
------------

// File: rtl/release_sink_unit.sv
// Manager-side TileLink C-channel sink: streams release/probe-ack data beats to the
// data array, answers each Release* with one ReleaseAck and reports completed ProbeAck*.
module release_sink_unit #(
  parameter int BEAT_BYTES = 16,
  parameter int MAX_SIZE   = 6,
  parameter int SINK_ID    = 0
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      c_valid,
  output logic                      c_ready,
  input  logic [2:0]                c_opcode,
  input  logic [2:0]                c_param,
  input  logic [3:0]                c_size,
  input  logic [2:0]                c_source,
  input  logic [31:0]               c_address,
  input  logic [8*BEAT_BYTES-1:0]   c_data,
  output logic                      d_valid,
  input  logic                      d_ready,
  output logic [2:0]                d_opcode,
  output logic [1:0]                d_param,
  output logic [3:0]                d_size,
  output logic [2:0]                d_source,
  output logic [3:0]                d_sink,
  output logic [8*BEAT_BYTES-1:0]   d_data,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic [31:0]               wb_addr,
  output logic [8*BEAT_BYTES-1:0]   wb_data,
  output logic                      wb_last,
  output logic                      probe_done,
  output logic [2:0]                probe_source,
  output logic [2:0]                probe_param,
  output logic                      err,
  output logic [1:0]                dbg_state
);

  localparam int OFF = $clog2(BEAT_BYTES);
  localparam int CW  = MAX_SIZE - OFF;

  // Handshakes: a beat transfers on the rising edge where valid && ready; the sender
  // holds all fields stable while valid is high and ready is low.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [2:0]      cap_op;
  logic [2:0]      cap_param;
  logic [3:0]      cap_size;
  logic [2:0]      cap_source;
  logic [31:0]     cap_addr;
  logic            probe_q, probe_nxt;
  logic            err_q, err_nxt;
  logic            cap_en;
  logic            active;

  logic            cur_data;
  logic [CW-1:0]   cur_mask;
  logic [CW-1:0]   cur_cnt;
  logic [31:0]     cur_base;
  logic [31:0]     c_base;
  logic [CW-1:0]   idx_sum;
  logic [CW-1:0]   idx_wrap;
  logic            last;
  logic            c_fire;

  function automatic logic is_data(input logic [2:0] op);
    return (op == 3'd5) || (op == 3'd7);
  endfunction

  // N-1 as a bit mask; oversize messages saturate at MAX_SIZE.
  function automatic logic [CW-1:0] beat_mask(input logic [3:0] size);
    logic [CW-1:0] m;
    m = '0;
    for (int i = 0; i < CW; i++) begin
      if (int'(size) > OFF + i) m[i] = 1'b1;
    end
    return m;
  endfunction

  assign c_base   = c_address & ~32'(BEAT_BYTES - 1);
  assign cur_data = (state == S_IDLE) ? is_data(c_opcode) : is_data(cap_op);
  assign cur_mask = (state == S_IDLE) ? beat_mask(c_size) : beat_mask(cap_size);
  assign cur_cnt  = (state == S_IDLE) ? '0 : cnt;
  assign cur_base = (state == S_IDLE) ? c_base : cap_addr;
  assign last     = (cur_cnt == cur_mask);

  // Beat index wraps inside the line; bits above the line are never carried into.
  assign idx_sum  = cur_base[OFF+CW-1:OFF] + cur_cnt;
  assign idx_wrap = (cur_base[OFF+CW-1:OFF] & ~cur_mask) | (idx_sum & cur_mask);

  always_comb begin
    c_ready = 1'b0;
    case (state)
      S_IDLE:  c_ready = active && (is_data(c_opcode) ? wb_ready : 1'b1);
      S_DATA:  c_ready = wb_ready;
      default: c_ready = 1'b0;
    endcase
  end

  assign c_fire   = c_valid && c_ready;
  assign wb_valid = active && c_valid && (state != S_ACK) && cur_data;
  assign wb_data  = active ? c_data : '0;
  assign wb_addr  = active ? {cur_base[31:OFF+CW], idx_wrap, cur_base[OFF-1:0]} : 32'd0;
  assign wb_last  = wb_valid && last;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cap_en    = 1'b0;
    probe_nxt = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (c_fire) begin
          err_nxt = !c_opcode[2] || (c_size > 4'(MAX_SIZE));
          // Opcodes 0-3 are consumed and dropped without touching captured state.
          if (c_opcode[2]) begin
            cap_en = 1'b1;
            if (cur_data && (cur_mask != '0)) begin
              state_nxt = S_DATA;
              cnt_nxt   = CW'(1);
            end else if (c_opcode[1]) begin
              state_nxt = S_ACK;
            end else begin
              probe_nxt = 1'b1;
            end
          end
        end
      end
      S_DATA: begin
        if (c_fire) begin
          if (last) begin
            cnt_nxt = '0;
            if (cap_op[1]) begin
              state_nxt = S_ACK;
            end else begin
              state_nxt = S_IDLE;
              probe_nxt = 1'b1;
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      S_ACK: begin
        if (d_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      cap_op     <= '0;
      cap_param  <= '0;
      cap_size   <= '0;
      cap_source <= '0;
      cap_addr   <= '0;
      probe_q    <= 1'b0;
      err_q      <= 1'b0;
      active     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      probe_q <= probe_nxt;
      err_q   <= err_nxt;
      active  <= 1'b1;
      if (cap_en) begin
        cap_op     <= c_opcode;
        cap_param  <= c_param;
        cap_size   <= c_size;
        cap_source <= c_source;
        cap_addr   <= c_base;
      end
    end
  end

  assign d_valid      = (state == S_ACK);
  assign d_opcode     = d_valid ? 3'd6 : 3'd0;
  assign d_param      = 2'd0;
  assign d_size       = d_valid ? cap_size : 4'd0;
  assign d_source     = d_valid ? cap_source : 3'd0;
  assign d_sink       = d_valid ? 4'(SINK_ID) : 4'd0;
  assign d_data       = '0;
  assign probe_done   = probe_q;
  assign probe_source = probe_q ? cap_source : 3'd0;
  assign probe_param  = probe_q ? cap_param : 3'd0;
  assign err          = err_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_release_sink_unit.sv
// Directed bench for release_sink_unit: drives C messages, checks data-array beats
// against an expected queue, and checks ReleaseAck / probe_done / err timing.
module tb_release_sink_unit;

  logic         clock, reset_n;
  logic         c_valid, c_ready;
  logic [2:0]   c_opcode, c_param, c_source;
  logic [3:0]   c_size;
  logic [31:0]  c_address;
  logic [127:0] c_data;
  logic         d_valid, d_ready;
  logic [2:0]   d_opcode, d_source;
  logic [1:0]   d_param;
  logic [3:0]   d_size, d_sink;
  logic [127:0] d_data;
  logic         wb_valid, wb_ready, wb_last;
  logic [31:0]  wb_addr;
  logic [127:0] wb_data;
  logic         probe_done, err;
  logic [2:0]   probe_source, probe_param;
  logic [1:0]   dbg_state;

  release_sink_unit dut (
    .clock(clock), .reset_n(reset_n),
    .c_valid(c_valid), .c_ready(c_ready), .c_opcode(c_opcode), .c_param(c_param),
    .c_size(c_size), .c_source(c_source), .c_address(c_address), .c_data(c_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_data(d_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_last(wb_last), .probe_done(probe_done), .probe_source(probe_source),
    .probe_param(probe_param), .err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int           checks = 0;
  int           failures = 0;
  logic [160:0] exp_q[$];
  bit           wbr_q[$];
  int           wb_fires;
  bit           err_pend = 1'b0;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] beat_data(input int b);
    return {4{32'hC0DE_0000 + 32'(b)}};
  endfunction

  function automatic logic [160:0] exp_beat(input logic [31:0] a, input int b, input bit l);
    return {a, beat_data(b), l};
  endfunction

  // One idle cycle: C channel quiet, err checked against any pending pulse.
  task automatic step();
    @(negedge clock);
    c_valid  = 1'b0;
    wb_ready = 1'b1;
    #1;
    chk("err", err, err_pend);
    err_pend = 1'b0;
  endtask

  task automatic send_msg(input logic [2:0] op, input logic [2:0] par, input logic [3:0] sz,
                          input logic [2:0] src, input logic [31:0] addr, input int nsend,
                          input bit exp_err);
    int sent = 0;
    int cyc = 0;
    bit data_op;
    logic [160:0] e;
    data_op = (op == 3'd5) || (op == 3'd7);
    wb_fires = 0;
    while (sent < nsend && cyc < 60) begin
      @(negedge clock);
      c_valid = 1'b1; c_opcode = op; c_param = par; c_size = sz;
      c_source = src; c_address = addr; c_data = beat_data(sent);
      wb_ready = (wbr_q.size() != 0) ? wbr_q.pop_front() : 1'b1;
      #1;
      chk("err", err, err_pend);
      err_pend = 1'b0;
      if (data_op) chk("c_ready_mirror", c_ready, wb_ready);
      else         chk("c_ready_nodata", c_ready, 1'b1);
      if (c_valid && c_ready) begin
        if (data_op) begin
          chk("wb_valid", wb_valid, 1'b1);
          if (exp_q.size() == 0) chk("wb_unexpected", 1'b1, 1'b0);
          else begin
            e = exp_q.pop_front();
            chk("wb_beat", {wb_addr, wb_data, wb_last}, e);
          end
          wb_fires++;
        end else begin
          chk("wb_valid_nodata", wb_valid, 1'b0);
        end
        if (sent == 0 && exp_err) err_pend = 1'b1;
        sent++;
      end
      cyc++;
    end
    if (sent < nsend) chk("send_timeout", 32'(sent), 32'(nsend));
  endtask

  // ReleaseAck expected in the cycle after the last C fire, held for 'hold' cycles.
  task automatic wait_ack(input logic [3:0] sz, input logic [2:0] src, input int hold);
    for (int k = 0; k <= hold; k++) begin
      step();
      d_ready = (k == hold);
      chk("d_valid", d_valid, 1'b1);
      chk("d_fields", {d_opcode, d_param, d_size, d_source, d_sink}, {3'd6, 2'd0, sz, src, 4'd0});
      chk("d_data", d_data, 128'd0);
      chk("c_ready_ack", c_ready, 1'b0);
    end
    step();
    chk("d_valid_after", d_valid, 1'b0);
    chk("state_idle", dbg_state, 2'd0);
    chk("c_ready_turn", c_ready, 1'b1);
    d_ready = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; c_valid = 1'b1; c_opcode = 3'd6; c_param = 3'd0; c_size = 4'd6;
    c_source = 3'd0; c_address = 32'd0; c_data = 128'd0; d_ready = 1'b1; wb_ready = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_outputs", {c_ready, d_valid, wb_valid, probe_done, err, dbg_state}, 7'd0);
    @(negedge clock);
    c_valid = 1'b0;
    reset_n = 1'b1;
    step();

    // Release, no data: ack in the next cycle, accept again the cycle after.
    send_msg(3'd6, 3'd1, 4'd6, 3'd3, 32'h2000, 1, 1'b0);
    wait_ack(4'd6, 3'd3, 0);

    // ReleaseData, 4 beats, wb_ready always high.
    exp_q.push_back(exp_beat(32'h1000, 0, 1'b0));
    exp_q.push_back(exp_beat(32'h1010, 1, 1'b0));
    exp_q.push_back(exp_beat(32'h1020, 2, 1'b0));
    exp_q.push_back(exp_beat(32'h1030, 3, 1'b1));
    send_msg(3'd7, 3'd0, 4'd6, 3'd1, 32'h1000, 4, 1'b0);
    chk("wb_fires_rd", 32'(wb_fires), 32'd4);
    wait_ack(4'd6, 3'd1, 0);

    // Same message with wb_ready back-pressure 1,0,0,1,1,0,1.
    wbr_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    exp_q.push_back(exp_beat(32'h1000, 0, 1'b0));
    exp_q.push_back(exp_beat(32'h1010, 1, 1'b0));
    exp_q.push_back(exp_beat(32'h1020, 2, 1'b0));
    exp_q.push_back(exp_beat(32'h1030, 3, 1'b1));
    send_msg(3'd7, 3'd0, 4'd6, 3'd1, 32'h1000, 4, 1'b0);
    chk("wb_fires_bp", 32'(wb_fires), 32'd4);
    chk("bp_pattern_used", 32'(wbr_q.size()), 32'd0);
    wait_ack(4'd6, 3'd1, 0);

    // ProbeAckData from an unaligned mid-line address: beats wrap inside the line.
    exp_q.push_back(exp_beat(32'h3020, 0, 1'b0));
    exp_q.push_back(exp_beat(32'h3030, 1, 1'b0));
    exp_q.push_back(exp_beat(32'h3000, 2, 1'b0));
    exp_q.push_back(exp_beat(32'h3010, 3, 1'b1));
    send_msg(3'd5, 3'd1, 4'd6, 3'd2, 32'h3025, 4, 1'b0);
    chk("wb_fires_pad", 32'(wb_fires), 32'd4);
    step();
    chk("probe_pulse", {probe_done, probe_source, probe_param}, {1'b1, 3'd2, 3'd1});
    chk("probe_no_ack", d_valid, 1'b0);
    step();
    chk("probe_single", probe_done, 1'b0);
    chk("probe_no_ack2", d_valid, 1'b0);

    // ReleaseAck held off by d_ready for 5 cycles.
    send_msg(3'd6, 3'd0, 4'd4, 3'd5, 32'h2040, 1, 1'b0);
    d_ready = 1'b0;
    wait_ack(4'd4, 3'd5, 5);

    // Illegal opcode: consumed, err, dropped.
    send_msg(3'd2, 3'd0, 4'd6, 3'd1, 32'h5000, 1, 1'b1);
    step();
    chk("bad_op_no_ack", d_valid, 1'b0);
    chk("bad_op_idle", dbg_state, 2'd0);
    step();

    // Oversize ReleaseData: err, processed as 4 beats, acked with the raw size.
    exp_q.push_back(exp_beat(32'h4000, 0, 1'b0));
    exp_q.push_back(exp_beat(32'h4010, 1, 1'b0));
    exp_q.push_back(exp_beat(32'h4020, 2, 1'b0));
    exp_q.push_back(exp_beat(32'h4030, 3, 1'b1));
    send_msg(3'd7, 3'd0, 4'd7, 3'd1, 32'h4000, 4, 1'b1);
    chk("wb_fires_big", 32'(wb_fires), 32'd4);
    wait_ack(4'd7, 3'd1, 0);

    // Reset in the middle of a ReleaseData: message abandoned, no ack.
    exp_q.push_back(exp_beat(32'h6000, 0, 1'b0));
    exp_q.push_back(exp_beat(32'h6010, 1, 1'b0));
    send_msg(3'd7, 3'd0, 4'd6, 3'd4, 32'h6000, 2, 1'b0);
    chk("mid_data_state", dbg_state, 2'd1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {c_ready, d_valid, wb_valid, wb_last, probe_done, err, dbg_state}, 8'd0);
    chk("rst_mid_wb", {wb_addr, wb_data}, 160'd0);
    @(negedge clock);
    c_valid = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_no_ack", {d_valid, probe_done}, 2'd0);
    end

    // Recovery: a plain Release still works.
    send_msg(3'd6, 3'd0, 4'd5, 3'd7, 32'h7000, 1, 1'b0);
    wait_ack(4'd5, 3'd7, 0);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
